// File: rtl/axi_mst_wr_scheduler.sv
// AW-channel write scheduler: splits one multi-beat command into INCR bursts (<=16 beats, no 4 KB crossing),
// allocates AXI IDs, bounds bursts in flight and retires them on B responses.
module axi_mst_wr_scheduler #(
    parameter int         AXI_ADDR_W      = 32,
    parameter int         AXI_ID_W        = 4,
    parameter logic [1:0] MST_ID_MASK     = 2'b01,
    parameter int         MST_OSTDREQ_NUM = 4,
    parameter int         MAX_BURST       = 16
) (
    input  logic                               aclk,
    input  logic                               srst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [AXI_ADDR_W-1:0]              cmd_addr,
    input  logic [11:0]                        cmd_beats,
    output logic                               awvalid,
    input  logic                               awready,
    output logic [AXI_ADDR_W-1:0]              awaddr,
    output logic [7:0]                         awlen,
    output logic [2:0]                         awsize,
    output logic [1:0]                         awburst,
    output logic [AXI_ID_W-1:0]                awid,
    input  logic                               bvalid,
    input  logic                               bready,
    input  logic [AXI_ID_W-1:0]                bid,
    input  logic [1:0]                         bresp,
    output logic [$clog2(MST_OSTDREQ_NUM):0]   ostd_cnt,
    output logic                               busy,
    output logic                               done,
    output logic                               resp_err
);

    localparam int LID_W  = AXI_ID_W - 2;
    localparam int NID    = 1 << LID_W;
    localparam int OSTD_W = $clog2(MST_OSTDREQ_NUM) + 1;
    localparam logic [OSTD_W-1:0] OSTD_MAX = OSTD_W'(MST_OSTDREQ_NUM);
    localparam logic [12:0]       MAXB     = 13'(MAX_BURST);

    typedef enum logic [1:0] {S_IDLE, S_SPLIT, S_ISSUE, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [AXI_ADDR_W-1:0]   addr_q, addr_d;
    logic [11:0]             rem_q, rem_d;
    logic [7:0]              len_q, len_d;
    logic [NID-1:0]          inuse_q, inuse_d;
    logic [OSTD_W-1:0]       ostd_q, ostd_d;
    logic                    err_q, err_d;
    logic                    pend_q, pend_d;
    logic [LID_W-1:0]        id_q, id_d;

    logic                    free_found;
    logic [LID_W-1:0]        free_id, id_sel, b_lid;
    logic                    aw_fire, b_hit, b_ret;
    logic [12:0]             to_4k, beats_new;
    logic [11:0]             beats_cur;

    // Lowest free ID from the registered in-use vector; same-cycle B frees show up next cycle.
    always_comb begin
        free_found = 1'b0;
        free_id    = '0;
        for (int i = NID - 1; i >= 0; i--) begin
            if (!inuse_q[i]) begin
                free_found = 1'b1;
                free_id    = LID_W'(i);
            end
        end
    end

    always_comb begin
        to_4k     = 13'h1000 - {1'b0, addr_q[11:0]};
        beats_new = MAXB;
        if ({1'b0, rem_q} < beats_new) beats_new = {1'b0, rem_q};
        if ({2'b00, to_4k[12:2]} < beats_new) beats_new = {2'b00, to_4k[12:2]};
        beats_cur = 12'(len_q) + 12'd1;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        len_d     = len_q;
        inuse_d   = inuse_q;
        ostd_d    = ostd_q;
        err_d     = err_q;
        pend_d    = pend_q;
        id_d      = id_q;
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        done      = 1'b0;
        aw_fire   = 1'b0;
        b_ret     = 1'b0;
        id_sel    = pend_q ? id_q : free_id;
        b_lid     = bid[LID_W-1:0];
        b_hit     = bvalid && bready && (bid[AXI_ID_W-1 -: 2] == MST_ID_MASK);

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = !srst;
                if (cmd_valid && !srst) begin
                    addr_d  = cmd_addr & ~AXI_ADDR_W'(3);
                    rem_d   = cmd_beats;
                    err_d   = (cmd_beats == 12'd0);
                    state_d = (cmd_beats == 12'd0) ? S_DRAIN : S_SPLIT;
                end
            end
            S_SPLIT: begin
                len_d   = 8'(beats_new - 13'd1);
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // Once offered, the burst (and its ID) is held until accepted.
                awvalid = pend_q || (free_found && (ostd_q < OSTD_MAX));
                if (awvalid && awready) begin
                    aw_fire         = 1'b1;
                    pend_d          = 1'b0;
                    inuse_d[id_sel] = 1'b1;
                    addr_d          = addr_q + AXI_ADDR_W'({beats_cur, 2'b00});
                    rem_d           = rem_q - beats_cur;
                    state_d         = (rem_q == beats_cur) ? S_DRAIN : S_SPLIT;
                end else if (awvalid) begin
                    pend_d = 1'b1;
                    id_d   = id_sel;
                end
            end
            S_DRAIN: begin
                if (inuse_q == '0) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (b_hit) begin
            if (inuse_q[b_lid]) begin
                inuse_d[b_lid] = 1'b0;
                b_ret          = 1'b1;
                if (bresp != 2'b00) err_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        if (aw_fire && !b_ret)      ostd_d = ostd_q + 1'b1;
        else if (!aw_fire && b_ret) ostd_d = ostd_q - 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            inuse_q <= '0;
            ostd_q  <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            inuse_q <= inuse_d;
            ostd_q  <= ostd_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            id_q    <= id_d;
        end
    end

    assign awaddr   = addr_q;
    assign awlen    = len_q;
    assign awsize   = 3'b010;
    assign awburst  = 2'b01;
    assign awid     = awvalid ? {MST_ID_MASK, id_sel} : '0;
    assign ostd_cnt = ostd_q;
    assign busy     = (state_q != S_IDLE);
    assign resp_err = err_q;

endmodule

// File: tb/tb_axi_mst_wr_scheduler.sv
// Scoreboard bench for axi_mst_wr_scheduler: expected AW bursts and done events are queued by the
// stimulus, and independent monitors pop and compare them as the DUT presents them.
module tb_axi_mst_wr_scheduler;

    logic        aclk;
    logic        srst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [11:0] cmd_beats;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;
    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic [2:0]  ostd_cnt;
    logic        busy;
    logic        done;
    logic        resp_err;

    int n_cmp = 0;
    int n_err = 0;
    logic b_auto = 1'b0;

    logic [43:0] exp_aw[$];
    logic        exp_done[$];
    logic [5:0]  bq[$];

    axi_mst_wr_scheduler dut (
        .aclk(aclk), .srst(srst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awid(awid),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .ostd_cnt(ostd_cnt), .busy(busy), .done(done), .resp_err(resp_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic exp_burst(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        exp_aw.push_back({a, l, id});
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] r);
        bq.push_back({id, r});
    endtask

    task automatic issue_cmd(input logic [31:0] a, input logic [11:0] n);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_beats = n;
        do begin
            @(negedge aclk);
            t++;
        end while (!cmd_ready && t < 200);
        if (!cmd_ready) timeout("cmd_accept");
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while (!done && t < 400);
        if (!done) timeout(nm);
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_ostd(input logic [2:0] v, input string nm);
        int t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while (ostd_cnt !== v && t < 400);
        if (ostd_cnt !== v) timeout(nm);
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_aw_left(input int n, input string nm);
        int t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while (exp_aw.size() > n && t < 400);
        if (exp_aw.size() > n) timeout(nm);
        @(posedge aclk);
        #1;
    endtask

    // B channel driver: one queued response per cycle
    initial begin
        logic [5:0] b;
        bvalid = 1'b0;
        bid    = '0;
        bresp  = '0;
        forever begin
            @(posedge aclk);
            #1;
            if (bq.size() > 0) begin
                b      = bq.pop_front();
                bvalid = 1'b1;
                bid    = b[5:2];
                bresp  = b[1:0];
            end else begin
                bvalid = 1'b0;
            end
        end
    end

    // Monitor: AW handshakes and done pulses against the scoreboard
    initial begin
        logic [43:0] e;
        logic        ed;
        forever begin
            @(negedge aclk);
            if (!srst && awvalid && awready) begin
                if (exp_aw.size() == 0) begin
                    chk("aw_unexpected", {awaddr, awlen, awid}, 44'h0);
                end else begin
                    e = exp_aw.pop_front();
                    chk("aw_addr_len_id", {awaddr, awlen, awid}, e);
                end
                if (b_auto) push_b(awid, 2'b00);
            end
            if (!srst && done) begin
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", done, 1'b0);
                end else begin
                    ed = exp_done.pop_front();
                    chk("done_resp_err", resp_err, ed);
                    chk("done_ostd_zero", ostd_cnt, 3'd0);
                end
            end
        end
    end

    initial begin
        logic stall_bad;
        bready    = 1'b1;
        srst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_beats = '0;
        awready   = 1'b1;
        repeat (3) @(posedge aclk);
        #1 srst = 1'b0;

        @(negedge aclk);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_ostd", ostd_cnt, 3'd0);
        chk("rst_busy_done_err", {busy, done, resp_err}, 3'b000);
        chk("rst_awsize_awburst", {awsize, awburst}, 5'b010_01);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        @(posedge aclk);
        #1;

        // single short command, immediate OKAY
        b_auto = 1'b1;
        exp_burst(32'h1000, 8'd4, 4'b0100);
        exp_done.push_back(1'b0);
        issue_cmd(32'h1000, 12'd5);
        @(negedge aclk);
        chk("lat_split_awvalid", awvalid, 1'b0);
        @(negedge aclk);
        chk("lat_issue_awvalid", awvalid, 1'b1);
        @(posedge aclk);
        #1;
        wait_done("t1_done");

        // split by length, B withheld so IDs 0/1/2 are used
        b_auto = 1'b0;
        exp_burst(32'h0000_0000, 8'd15, 4'b0100);
        exp_burst(32'h0000_0040, 8'd15, 4'b0101);
        exp_burst(32'h0000_0080, 8'd7,  4'b0110);
        exp_done.push_back(1'b0);
        issue_cmd(32'h0, 12'd40);
        wait_ostd(3'd3, "t2_ostd");
        push_b(4'b0100, 2'b00);
        push_b(4'b0101, 2'b00);
        push_b(4'b0110, 2'b00);
        wait_done("t2_done");

        // 4 KB boundary
        exp_burst(32'h0000_0FF0, 8'd3, 4'b0100);
        exp_burst(32'h0000_1000, 8'd5, 4'b0101);
        exp_done.push_back(1'b0);
        issue_cmd(32'h0FF0, 12'd10);
        wait_ostd(3'd2, "t3_ostd");
        push_b(4'b0100, 2'b00);
        push_b(4'b0101, 2'b00);
        wait_done("t3_done");

        // outstanding limit
        exp_burst(32'h2000, 8'd15, 4'b0100);
        exp_burst(32'h2040, 8'd15, 4'b0101);
        exp_burst(32'h2080, 8'd15, 4'b0110);
        exp_burst(32'h20C0, 8'd15, 4'b0111);
        exp_burst(32'h2100, 8'd15, 4'b0110);
        exp_burst(32'h2140, 8'd15, 4'b0100);
        exp_burst(32'h2180, 8'd3,  4'b0101);
        exp_done.push_back(1'b0);
        issue_cmd(32'h2000, 12'd100);
        wait_ostd(3'd4, "t4_ostd_full");
        stall_bad = 1'b0;
        repeat (6) begin
            @(negedge aclk);
            if (awvalid) stall_bad = 1'b1;
        end
        chk("t4_stall_awvalid", stall_bad, 1'b0);
        chk("t4_stall_ostd", ostd_cnt, 3'd4);
        @(posedge aclk);
        #1 push_b(4'b0110, 2'b00);
        wait_aw_left(2, "t4_aw5");
        b_auto = 1'b1;
        push_b(4'b0100, 2'b00);
        push_b(4'b0101, 2'b00);
        push_b(4'b0111, 2'b00);
        push_b(4'b0110, 2'b00);
        wait_done("t4_done");

        // error response, foreign-mask B ignored
        b_auto = 1'b0;
        exp_burst(32'h3000, 8'd1, 4'b0100);
        exp_done.push_back(1'b1);
        issue_cmd(32'h3003, 12'd2);
        wait_ostd(3'd1, "t5_ostd");
        push_b(4'b1000, 2'b00);
        repeat (4) @(negedge aclk);
        chk("t5_foreign_b_ostd", ostd_cnt, 3'd1);
        chk("t5_foreign_b_err", resp_err, 1'b0);
        push_b(4'b0100, 2'b10);
        wait_done("t5_done");

        // next accept clears resp_err
        b_auto = 1'b1;
        exp_burst(32'h3000, 8'd0, 4'b0100);
        exp_done.push_back(1'b0);
        issue_cmd(32'h3000, 12'd1);
        @(negedge aclk);
        chk("t6_err_cleared", resp_err, 1'b0);
        wait_done("t6_done");

        // B for an ID not in use
        b_auto = 1'b0;
        push_b(4'b0111, 2'b00);
        repeat (4) @(negedge aclk);
        chk("t7_unused_id_err", resp_err, 1'b1);
        chk("t7_unused_id_ostd", ostd_cnt, 3'd0);
        @(posedge aclk);
        #1;

        // zero-beat command
        exp_done.push_back(1'b1);
        issue_cmd(32'h7000, 12'd0);
        wait_done("t8_done");

        // reset mid-burst
        exp_burst(32'h4000, 8'd15, 4'b0100);
        issue_cmd(32'h4000, 12'd20);
        wait_aw_left(0, "t9_aw1");
        awready = 1'b0;
        begin
            int t = 0;
            do begin
                @(negedge aclk);
                t++;
            end while (!awvalid && t < 50);
            if (!awvalid) timeout("t9_aw2_valid");
        end
        @(posedge aclk);
        #1 srst = 1'b1;
        @(posedge aclk);
        #1 srst = 1'b0;
        @(negedge aclk);
        chk("t9_rst_awvalid", awvalid, 1'b0);
        chk("t9_rst_ostd", ostd_cnt, 3'd0);
        chk("t9_rst_busy_ready", {busy, cmd_ready}, 2'b01);
        @(posedge aclk);
        #1 awready = 1'b1;
        b_auto = 1'b1;
        exp_burst(32'h5000, 8'd0, 4'b0100);
        exp_done.push_back(1'b0);
        issue_cmd(32'h5000, 12'd1);
        wait_done("t9_done");

        repeat (3) @(posedge aclk);
        chk("aw_all_seen", exp_aw.size(), 0);
        chk("done_all_seen", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
